exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Multicycle sequencer that takes the CPU from exception detection to the first handler fetch.
- Prioritises the three exception sources (invalid opcode, overflow, divide-by-zero) and latches the winner.
- Drives the 2-bit select of the exception-vector mux (253/254/255), then sequences EPC save, vector byte read and PC load.
- Sits beside the main control unit; owns the datapath only while busy is high.

Parameters:
- MEM_WAIT, default 1: wait cycles between issuing the vector read and the memory byte being valid (range 0..7).
- EPC_OFFSET, default 4: value subtracted from PC to form EPC; documentation and assertion use only, since the subtract is done in the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- excpt_window  in  1  control unit signals an exception may be taken this cycle (end of decode/execute).
- opcode_inv  in  1  invalid-opcode flag.
- overflow  in  1  ALU overflow flag.
- div0  in  1  divider divide-by-zero flag.
- mem_byte  in  8  byte returned by memory at the vector address.
- ExcptCtrl  out  2  exception-vector mux select: 00 → 253, 01 → 254, 1x → 255.
- busy  out  1  sequencer owns the datapath; control unit stalls.
- epc_write  out  1  EPC load enable (ALU result PC−EPC_OFFSET).
- alu_sub_pc  out  1  forces ALU to compute PC−EPC_OFFSET.
- mem_addr_excpt  out  1  memory address mux selects exception-vector mux output.
- mem_read  out  1  memory read strobe.
- pc_write  out  1  PC load enable.
- pc_src_excpt  out  1  PC source = zero-extended mem_byte.
- excpt_done  out  1  one-cycle pulse; the next cycle is a normal fetch.

Behaviour:
- Reset (asynchronous): state IDLE, ExcptCtrl=00, all other outputs 0, wait counter 0.
- Priority: div0 > overflow > opcode_inv. Encoded cause: div0 → 10, overflow → 01, opcode_inv → 00.
- Flags are sampled only when excpt_window=1. Flags outside the window are ignored.
- States:
  - IDLE: if excpt_window and any flag, latch the encoded cause into ExcptCtrl and go to SAVE_EPC; otherwise stay.
  - SAVE_EPC (1 cycle): busy, alu_sub_pc, epc_write → READ_VEC.
  - READ_VEC (1 cycle): busy, mem_addr_excpt, mem_read; load wait counter with MEM_WAIT. Go to WAIT if MEM_WAIT>0, else LOAD_PC.
  - WAIT: busy, mem_addr_excpt held; decrement counter. At 1 → LOAD_PC.
  - LOAD_PC (1 cycle): busy, pc_write, pc_src_excpt; PC ← {24'b0, mem_byte} → DONE.
  - DONE (1 cycle): excpt_done=1, busy=0 → IDLE.
- Latency, flag to handler fetch: 4+MEM_WAIT cycles (default 5).
- ExcptCtrl holds the latched cause from SAVE_EPC through DONE. It returns to 00 in IDLE.
- Flags arriving while busy are masked; no queuing, no nesting.
- All outputs are Moore, decoded from state only. busy is high in SAVE_EPC..LOAD_PC.
- Simultaneous flags: only the highest priority cause is taken; the rest are lost.
- Reset mid-sequence: immediate return to IDLE. A partially written EPC is not restored.

Optional Feature:
- Macro: EXCPT_CAUSE_LOG_EN.
- When defined:
  - Adds input cause_clr (1) and output cause_log (3), a sticky bitmap {div0, overflow, opcode_inv}.
  - Each bit sets when its flag is seen with excpt_window=1 in IDLE, including losers of the priority.
  - cause_clr clears the bitmap; set wins over clear in the same cycle.
  - Reset value is 000.
- When undefined: neither port exists and no log register is built.

Decomposition:
- Shared package holds:
  - state typedef: IDLE, SAVE_EPC, READ_VEC, WAIT, LOAD_PC, DONE.
  - ExcptCtrl encodings: SEL_OPCODE=2'b00, SEL_OVF=2'b01, SEL_DIV0=2'b10.
  - vector constants 253/254/255, shared with the mux.
- One sub-module is natural: excpt_prio_enc, a combinational 3→2 priority encoder plus valid bit.

Test Plan:
- Overflow alone with window=1, mem_byte=0x40, MEM_WAIT=1 → ExcptCtrl=01; epc_write in cycle 1; mem_read in cycle 2; pc_write in cycle 4 with PC=0x00000040; excpt_done in cycle 5.
- div0 and overflow and opcode_inv together → ExcptCtrl=10, one sequence only; with EXCPT_CAUSE_LOG_EN, cause_log=111.
- opcode_inv with window=0 → stays IDLE, busy=0; a later window=1 with opcode_inv → ExcptCtrl=00, sequence runs.
- overflow pulsed during WAIT → ignored; a single excpt_done; ExcptCtrl unchanged.
- Reset asserted in READ_VEC → asynchronously IDLE, all outputs 0, no pc_write.
- MEM_WAIT=0 → LOAD_PC directly follows READ_VEC; total 4 cycles to excpt_done.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception sequencer and the exception-vector mux.
package exception_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_EPC = 3'd1,
    READ_VEC = 3'd2,
    WAIT     = 3'd3,
    LOAD_PC  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [1:0] SEL_OPCODE = 2'b00;
  localparam logic [1:0] SEL_OVF    = 2'b01;
  localparam logic [1:0] SEL_DIV0   = 2'b10;

  localparam logic [7:0] VEC_OPCODE = 8'd253;
  localparam logic [7:0] VEC_OVF    = 8'd254;
  localparam logic [7:0] VEC_DIV0   = 8'd255;

  // Byte address the vector mux produces for a given select (1x both map to 255).
  function automatic logic [7:0] vec_addr(input logic [1:0] sel);
    logic [7:0] addr;
    addr = VEC_DIV0;
    if (sel == SEL_OPCODE) addr = VEC_OPCODE;
    else if (sel == SEL_OVF) addr = VEC_OVF;
    return addr;
  endfunction

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Combinational priority encoder for the three exception flags: div0 > overflow > opcode_inv.
module excpt_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic       opcode_inv,
  input  logic       overflow,
  input  logic       div0,
  output logic [1:0] cause,
  output logic       valid
);

  always_comb begin
    cause = SEL_OPCODE;
    valid = opcode_inv | overflow | div0;
    if (div0)          cause = SEL_DIV0;
    else if (overflow) cause = SEL_OVF;
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer: cause latch, EPC save, vector read, PC load, done pulse.
// Optional sticky cause bitmap built only when EXCPT_CAUSE_LOG_EN is defined.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 1,
  parameter int unsigned EPC_OFFSET = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       excpt_window,
  input  logic       opcode_inv,
  input  logic       overflow,
  input  logic       div0,
  input  logic [7:0] mem_byte,
`ifdef EXCPT_CAUSE_LOG_EN
  input  logic       cause_clr,
  output logic [2:0] cause_log,
`endif
  output logic [1:0] ExcptCtrl,
  output logic       busy,
  output logic       epc_write,
  output logic       alu_sub_pc,
  output logic       mem_addr_excpt,
  output logic       mem_read,
  output logic       pc_write,
  output logic       pc_src_excpt,
  output logic       excpt_done,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] MEM_WAIT_W = 3'(MEM_WAIT);

  // EPC_OFFSET only documents the ALU subtract; reject nonsensical values at elaboration.
  if (MEM_WAIT > 7 || EPC_OFFSET == 0) begin : g_bad_param
    $error("exception_ctrl: MEM_WAIT must be 0..7 and EPC_OFFSET nonzero");
  end

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  logic [1:0] cause_q;
  logic [1:0] enc_cause;
  logic       enc_valid;
  logic       take;

  excpt_prio_enc u_prio (
    .opcode_inv (opcode_inv),
    .overflow   (overflow),
    .div0       (div0),
    .cause      (enc_cause),
    .valid      (enc_valid)
  );

  assign take = (state == IDLE) && excpt_window && enc_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      cause_q  <= SEL_OPCODE;
    end else begin
      state <= state_nxt;
      if (take) cause_q <= enc_cause;
      if (state == READ_VEC)  wait_cnt <= MEM_WAIT_W;
      else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;
      else                    wait_cnt <= 3'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take) state_nxt = SAVE_EPC;
      SAVE_EPC: state_nxt = READ_VEC;
      READ_VEC: state_nxt = (MEM_WAIT_W != 3'd0) ? WAIT : LOAD_PC;
      WAIT:     if (wait_cnt <= 3'd1) state_nxt = LOAD_PC;
      LOAD_PC:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Moore decode; the mux select shows the latched cause only outside IDLE.
  always_comb begin
    ExcptCtrl      = SEL_OPCODE;
    busy           = 1'b0;
    epc_write      = 1'b0;
    alu_sub_pc     = 1'b0;
    mem_addr_excpt = 1'b0;
    mem_read       = 1'b0;
    pc_write       = 1'b0;
    pc_src_excpt   = 1'b0;
    excpt_done     = 1'b0;
    if (state != IDLE) ExcptCtrl = cause_q;
    case (state)
      SAVE_EPC: begin
        busy       = 1'b1;
        alu_sub_pc = 1'b1;
        epc_write  = 1'b1;
      end
      READ_VEC: begin
        busy           = 1'b1;
        mem_addr_excpt = 1'b1;
        mem_read       = 1'b1;
      end
      WAIT: begin
        busy           = 1'b1;
        mem_addr_excpt = 1'b1;
      end
      LOAD_PC: begin
        busy         = 1'b1;
        pc_write     = 1'b1;
        pc_src_excpt = 1'b1;
      end
      DONE:    excpt_done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

`ifdef EXCPT_CAUSE_LOG_EN
  logic [2:0] log_set;

  // Every flag seen in an IDLE window is logged, including priority losers.
  assign log_set = (state == IDLE && excpt_window) ? {div0, overflow, opcode_inv} : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cause_log <= 3'b000;
    else       cause_log <= (cause_log & ~{3{cause_clr}}) | log_set;
  end
`else
  // No cause log in this build.
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl (MEM_WAIT=1 and MEM_WAIT=0 instances).
module tb_exception_ctrl;
  import exception_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       excpt_window = 1'b0;
  logic       opcode_inv = 1'b0;
  logic       overflow = 1'b0;
  logic       div0 = 1'b0;
  logic [7:0] mem_byte = 8'h00;
  logic       cause_clr = 1'b0;

  logic [1:0] sel, sel0;
  logic       busy, epc_write, alu_sub_pc, mem_addr_excpt, mem_read, pc_write, pc_src_excpt, excpt_done;
  logic       busy0, epc_write0, alu_sub_pc0, mem_addr_excpt0, mem_read0, pc_write0, pc_src_excpt0, excpt_done0;
  logic [2:0] dbg_state, dbg_state0;
  logic [2:0] cause_log, cause_log0;

  logic [7:0] ctl_obs, ctl_obs0;
  logic [31:0] pc_model = 32'hdead_beef;
  logic [31:0] pc0_model = 32'hdead_beef;

  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exception_ctrl #(.MEM_WAIT(1)) u_dut (
    .clk(clk), .reset(reset), .excpt_window(excpt_window), .opcode_inv(opcode_inv),
    .overflow(overflow), .div0(div0), .mem_byte(mem_byte),
`ifdef EXCPT_CAUSE_LOG_EN
    .cause_clr(cause_clr), .cause_log(cause_log),
`endif
    .ExcptCtrl(sel), .busy(busy), .epc_write(epc_write), .alu_sub_pc(alu_sub_pc),
    .mem_addr_excpt(mem_addr_excpt), .mem_read(mem_read), .pc_write(pc_write),
    .pc_src_excpt(pc_src_excpt), .excpt_done(excpt_done), .dbg_state(dbg_state)
  );

  exception_ctrl #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .excpt_window(excpt_window), .opcode_inv(opcode_inv),
    .overflow(overflow), .div0(div0), .mem_byte(mem_byte),
`ifdef EXCPT_CAUSE_LOG_EN
    .cause_clr(cause_clr), .cause_log(cause_log0),
`endif
    .ExcptCtrl(sel0), .busy(busy0), .epc_write(epc_write0), .alu_sub_pc(alu_sub_pc0),
    .mem_addr_excpt(mem_addr_excpt0), .mem_read(mem_read0), .pc_write(pc_write0),
    .pc_src_excpt(pc_src_excpt0), .excpt_done(excpt_done0), .dbg_state(dbg_state0)
  );

`ifndef EXCPT_CAUSE_LOG_EN
  assign cause_log  = 3'b000;
  assign cause_log0 = 3'b000;
`endif

  assign ctl_obs  = {busy, epc_write, alu_sub_pc, mem_addr_excpt, mem_read, pc_write, pc_src_excpt, excpt_done};
  assign ctl_obs0 = {busy0, epc_write0, alu_sub_pc0, mem_addr_excpt0, mem_read0, pc_write0, pc_src_excpt0, excpt_done0};

  // Bench-side PC registers fed by the sequencer's load enables.
  always @(posedge clk) begin
    if (pc_write && pc_src_excpt)   pc_model  <= {24'b0, mem_byte};
    if (pc_write0 && pc_src_excpt0) pc0_model <= {24'b0, mem_byte};
  end

  function automatic logic [1:0] exp_cause(input logic inv, input logic ovf, input logic d0);
    if (d0)  return 2'b10;
    if (ovf) return 2'b01;
    return 2'b00;
  endfunction

  // Driver: present flags for one edge; returns at the first cycle after sampling.
  task automatic pulse(input logic win, input logic inv, input logic ovf, input logic d0);
    @(negedge clk);
    excpt_window = win; opcode_inv = inv; overflow = ovf; div0 = d0;
    if (win && (inv || ovf || d0)) exp_q.push_back({exp_cause(inv, ovf, d0), mem_byte});
    @(negedge clk);
    excpt_window = 1'b0; opcode_inv = 1'b0; overflow = 1'b0; div0 = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (excpt_done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({ctl_obs, sel, dbg_state} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_async: ctl=%b sel=%b state=%0d, want all 0", ctl_obs, sel, dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({ctl_obs0, sel0, dbg_state0, cause_log, cause_log0} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_dut0: ctl=%b sel=%b state=%0d log=%b/%b, want all 0",
               ctl_obs0, sel0, dbg_state0, cause_log, cause_log0);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || dbg_state !== 3'(IDLE)) begin
      n_err++;
      $display("FAIL reset_release: busy=%b state=%0d, want 0/IDLE", busy, dbg_state);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] tbl [5];
    logic [9:0] e;
    tbl[0] = 8'b1110_0000; tbl[1] = 8'b1001_1000; tbl[2] = 8'b1001_0000;
    tbl[3] = 8'b1000_0110; tbl[4] = 8'b0000_0001;
    mem_byte = 8'h40;
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_vec++;
      if (ctl_obs !== tbl[c] || sel !== SEL_OVF) begin
        n_err++;
        $display("FAIL ovf_cycle%0d: ctl=%b sel=%b, want ctl=%b sel=%b", c + 1, ctl_obs, sel, tbl[c], SEL_OVF);
      end
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL ovf_sb: queue empty at excpt_done, want one entry");
    end else begin
      e = exp_q.pop_front();
      if (pc_model !== {24'b0, e[7:0]} || sel !== e[9:8]) begin
        n_err++;
        $display("FAIL ovf_sb: pc=%h sel=%b, want pc=%h sel=%b", pc_model, sel, {24'b0, e[7:0]}, e[9:8]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (sel !== SEL_OPCODE || busy !== 1'b0 || dbg_state !== 3'(IDLE)) begin
      n_err++;
      $display("FAIL ovf_idle: sel=%b busy=%b state=%0d, want 00/0/IDLE", sel, busy, dbg_state);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e;
    bit seen;
    int extra;
    mem_byte = 8'h55;
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (sel !== SEL_DIV0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL simul_sel: sel=%b busy=%b, want 10/1", sel, busy);
    end
    wait_done(10, seen);
    n_vec++;
    if (!seen || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL simul_done: seen=%0d q=%0d, want done with one entry", seen, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (pc_model !== {24'b0, e[7:0]} || sel !== e[9:8]) begin
        n_err++;
        $display("FAIL simul_sb: pc=%h sel=%b, want pc=%h sel=%b", pc_model, sel, {24'b0, e[7:0]}, e[9:8]);
      end
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || excpt_done) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL simul_single: %0d extra busy/done cycles, want 0", extra);
    end
`ifdef EXCPT_CAUSE_LOG_EN
    n_vec++;
    if (cause_log !== 3'b111) begin
      n_err++;
      $display("FAIL simul_log: cause_log=%b, want 111", cause_log);
    end
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    n_vec++;
    if (cause_log !== 3'b000) begin
      n_err++;
      $display("FAIL log_clear: cause_log=%b, want 000", cause_log);
    end
`endif
  endtask

  task automatic test_window();
    logic [9:0] e;
    bit seen;
    int bad;
    mem_byte = 8'h33;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || dbg_state !== 3'(IDLE)) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL window_closed: %0d busy cycles, want 0", bad);
    end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (sel !== SEL_OPCODE || busy !== 1'b1 || dbg_state !== 3'(SAVE_EPC)) begin
      n_err++;
      $display("FAIL window_open: sel=%b busy=%b state=%0d, want 00/1/SAVE_EPC", sel, busy, dbg_state);
    end
    wait_done(10, seen);
    n_vec++;
    if (!seen || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL window_done: seen=%0d q=%0d, want done with one entry", seen, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (pc_model !== {24'b0, e[7:0]} || sel !== e[9:8]) begin
        n_err++;
        $display("FAIL window_sb: pc=%h sel=%b, want pc=%h sel=%b", pc_model, sel, {24'b0, e[7:0]}, e[9:8]);
      end
    end
  endtask

  task automatic test_masked();
    logic [9:0] e;
    bit seen;
    int extra;
    mem_byte = 8'h21;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (dbg_state !== 3'(WAIT) || mem_addr_excpt !== 1'b1) begin
      n_err++;
      $display("FAIL masked_wait: state=%0d addr=%b, want WAIT/1", dbg_state, mem_addr_excpt);
    end
    excpt_window = 1'b1; overflow = 1'b1;
    @(negedge clk);
    excpt_window = 1'b0; overflow = 1'b0;
    n_vec++;
    if (sel !== SEL_OPCODE) begin
      n_err++;
      $display("FAIL masked_sel: sel=%b, want 00", sel);
    end
    wait_done(10, seen);
    n_vec++;
    if (!seen || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL masked_done: seen=%0d q=%0d, want done with one entry", seen, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (pc_model !== {24'b0, e[7:0]} || sel !== e[9:8]) begin
        n_err++;
        $display("FAIL masked_sb: pc=%h sel=%b, want pc=%h sel=%b", pc_model, sel, {24'b0, e[7:0]}, e[9:8]);
      end
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || excpt_done) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL masked_single: %0d extra busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc_save;
    int writes;
    mem_byte = 8'h7f;
    pc_save = pc_model;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (dbg_state !== 3'(READ_VEC) || mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: state=%0d mem_read=%b, want READ_VEC/1", dbg_state, mem_read);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({ctl_obs, sel, dbg_state} !== 13'd0 || {ctl_obs0, sel0, dbg_state0} !== 13'd0) begin
      n_err++;
      $display("FAIL midrst_async: ctl=%b sel=%b state=%0d ctl0=%b, want all 0", ctl_obs, sel, dbg_state, ctl_obs0);
    end
    @(negedge clk);
    reset = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_write || busy) writes++;
    end
    n_vec++;
    if (writes !== 0 || pc_model !== pc_save) begin
      n_err++;
      $display("FAIL midrst_nopc: writes=%0d pc=%h, want 0 and pc=%h", writes, pc_model, pc_save);
    end
  endtask

  task automatic test_mem_wait0();
    logic [7:0] tbl [4];
    logic [9:0] e;
    bit seen;
    tbl[0] = 8'b1110_0000; tbl[1] = 8'b1001_1000; tbl[2] = 8'b1000_0110; tbl[3] = 8'b0000_0001;
    mem_byte = 8'h9a;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      n_vec++;
      if (ctl_obs0 !== tbl[c] || sel0 !== SEL_DIV0) begin
        n_err++;
        $display("FAIL wait0_cycle%0d: ctl=%b sel=%b, want ctl=%b sel=%b", c + 1, ctl_obs0, sel0, tbl[c], SEL_DIV0);
      end
    end
    n_vec++;
    if (pc0_model !== 32'h0000_009a) begin
      n_err++;
      $display("FAIL wait0_pc: pc=%h, want 0000009a", pc0_model);
    end
    wait_done(6, seen);
    n_vec++;
    if (!seen || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL wait0_main_done: seen=%0d q=%0d, want done with one entry", seen, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (pc_model !== {24'b0, e[7:0]} || sel !== e[9:8]) begin
        n_err++;
        $display("FAIL wait0_sb: pc=%h sel=%b, want pc=%h sel=%b", pc_model, sel, {24'b0, e[7:0]}, e[9:8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    logic [2:0] f;
    bit seen;
    for (int n = 0; n < 6; n++) begin
      f = 3'($urandom_range(1, 7));
      mem_byte = 8'($urandom_range(0, 255));
      pulse(1'b1, f[0], f[1], f[2]);
      wait_done(10, seen);
      n_vec++;
      if (!seen || exp_q.size() == 0) begin
        n_err++;
        $display("FAIL b2b_done%0d: seen=%0d q=%0d, want done with one entry", n, seen, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (pc_model !== {24'b0, e[7:0]} || sel !== e[9:8]) begin
          n_err++;
          $display("FAIL b2b_sb%0d: pc=%h sel=%b, want pc=%h sel=%b", n, pc_model, sel, {24'b0, e[7:0]}, e[9:8]);
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: q=%0d busy=%b, want 0/0", exp_q.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overflow();
    test_simultaneous();
    test_window();
    test_masked();
    test_reset_mid();
    test_mem_wait0();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
